hex_display_pager: RTL and testbench

HEX_DISPLAY_PAGER -- requirements
Module: hex_display_pager

---
 rtl/hex_display_pager.sv | 181 ++++++++++++++++++
 tb/tb_hex_display_pager.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hex_display_pager.sv
// hex_display_pager: shows a 32-bit debug word on six 7-segment digits, two pages.
// Latency: VDATA -> HEX 2 cycles; debounced key press -> page/HEX 1 cycle after the press pulse.
// Backpressure: none; free-running display path, inputs sampled every cycle.
//
// Ports:
//   CLK, RST_N        50 MHz board clock, asynchronous active-low reset
//   VDATA, SEL        debug word and the selector code that produced it
//   KEY_PAGE          raw push-button, active-low; each press toggles the page
//   FREEZE            raw slide switch; 1 holds the displayed snapshot
//   HEX0..HEX5        active-low digits {dp,g,f,e,d,c,b,a}
//   PAGE_LED          current page (0 = low 24 bits, 1 = high 16 bits + SEL)
module hex_display_pager #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] VDATA,
   input  logic [2:0]  SEL,
   input  logic        KEY_PAGE,
   input  logic        FREEZE,
   output logic [7:0]  HEX0,
   output logic [7:0]  HEX1,
   output logic [7:0]  HEX2,
   output logic [7:0]  HEX3,
   output logic [7:0]  HEX4,
   output logic [7:0]  HEX5,
   output logic        PAGE_LED
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Active-low segment pattern {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   logic          key_s1, key_s2, frz_s1, frz_s2;
   logic          key_stable, frz_stable;
   logic [CW-1:0] key_cnt, frz_cnt;
   logic [1:0]    sync_ok;
   logic          armed;
   logic          press_evt;
   logic          page;
   logic          out_en;
   logic [31:0]   snap_data;
   logic [2:0]    snap_sel;
   logic          key_accept, frz_accept;
   logic          page_nxt;
   logic [7:0]    hex_nxt [6];

   // Two-flop synchronizers; key idles high (released), freeze idles low.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
         frz_s1 <= 1'b0;
         frz_s2 <= 1'b0;
      end else begin
         key_s1 <= KEY_PAGE;
         key_s2 <= key_s1;
         frz_s1 <= FREEZE;
         frz_s2 <= frz_s1;
      end
   end

   // A change is accepted once the synced value has differed for DEBOUNCE_CYCLES cycles.
   assign key_accept = (key_s2 != key_stable) && (key_cnt == CNT_LAST);
   assign frz_accept = (frz_s2 != frz_stable) && (frz_cnt == CNT_LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         key_stable <= 1'b1;
         key_cnt    <= '0;
         frz_stable <= 1'b0;
         frz_cnt    <= '0;
      end else begin
         if (key_s2 == key_stable || key_accept)
            key_cnt <= '0;
         else
            key_cnt <= key_cnt + 1'b1;
         if (key_accept)
            key_stable <= key_s2;

         if (frz_s2 == frz_stable || frz_accept)
            frz_cnt <= '0;
         else
            frz_cnt <= frz_cnt + 1'b1;
         if (frz_accept)
            frz_stable <= frz_s2;
      end
   end

   // Press events are armed only after the key has been seen released with the
   // synchronizer holding real samples, so a key held through reset stays silent
   // until it is released and pressed again.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_ok   <= 2'b00;
         armed     <= 1'b0;
         press_evt <= 1'b0;
         page      <= 1'b0;
      end else begin
         sync_ok   <= {sync_ok[0], 1'b1};
         armed     <= armed | (sync_ok[1] & key_s2 & key_stable);
         press_evt <= armed & key_accept & key_stable & ~key_s2;
         page      <= page_nxt;
      end
   end

   assign page_nxt = page ^ press_evt;
   assign PAGE_LED = page;

   // Snapshot follows the live word until the debounced freeze switch is on.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         snap_data <= '0;
         snap_sel  <= '0;
      end else if (!frz_stable) begin
         snap_data <= VDATA;
         snap_sel  <= SEL;
      end
   end

   // Digit contents use the next page value so a toggle lands together with PAGE_LED.
   always_comb begin
      for (int i = 0; i < 6; i++)
         hex_nxt[i] = {1'b1, seg7(snap_data[4*i +: 4])};
      if (page_nxt) begin
         for (int i = 0; i < 4; i++)
            hex_nxt[i] = {1'b1, seg7(snap_data[16 + 4*i +: 4])};
         hex_nxt[4] = 8'hFF;
         hex_nxt[5] = {1'b1, seg7({1'b0, snap_sel})};
      end
      hex_nxt[5][7] = ~frz_stable;
   end

   // out_en holds the digits blank on the first edge after reset, while the
   // snapshot is still loading its first sample.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_en <= 1'b0;
         HEX0   <= 8'hFF;
         HEX1   <= 8'hFF;
         HEX2   <= 8'hFF;
         HEX3   <= 8'hFF;
         HEX4   <= 8'hFF;
         HEX5   <= 8'hFF;
      end else begin
         out_en <= 1'b1;
         if (out_en) begin
            HEX0 <= hex_nxt[0];
            HEX1 <= hex_nxt[1];
            HEX2 <= hex_nxt[2];
            HEX3 <= hex_nxt[3];
            HEX4 <= hex_nxt[4];
            HEX5 <= hex_nxt[5];
         end
      end
   end

endmodule

// File: tb/tb_hex_display_pager.sv
// Directed bench for hex_display_pager with DEBOUNCE_CYCLES = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hex_display_pager;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [31:0] VDATA;
   logic [2:0]  SEL;
   logic        KEY_PAGE;
   logic        FREEZE;
   logic [7:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic        PAGE_LED;

   int passed = 0;
   int total  = 0;

   hex_display_pager #(.DEBOUNCE_CYCLES(4)) dut (
      .CLK(CLK), .RST_N(RST_N), .VDATA(VDATA), .SEL(SEL),
      .KEY_PAGE(KEY_PAGE), .FREEZE(FREEZE),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
      .PAGE_LED(PAGE_LED)
   );

   always #5 CLK = ~CLK;

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
   endtask

   task automatic check_all_blank(input string tag);
      check({tag, "_hex0"}, HEX0, 8'hFF);
      check({tag, "_hex1"}, HEX1, 8'hFF);
      check({tag, "_hex2"}, HEX2, 8'hFF);
      check({tag, "_hex3"}, HEX3, 8'hFF);
      check({tag, "_hex4"}, HEX4, 8'hFF);
      check({tag, "_hex5"}, HEX5, 8'hFF);
      check({tag, "_led"}, {7'b0, PAGE_LED}, 8'h00);
   endtask

   initial begin
      RST_N = 1'b0; KEY_PAGE = 1'b1; FREEZE = 1'b0;
      VDATA = 32'h12345678; SEL = 3'b011;
      tick(2);
      check_all_blank("reset");

      // Release: first edge keeps blanks, second shows the word.
      RST_N = 1'b1;
      tick(1);
      check("first_edge_blank", HEX0, 8'hFF);
      tick(1);
      check("p0_hex5", HEX5, 8'hB0);
      check("p0_hex4", HEX4, 8'h99);
      check("p0_hex3", HEX3, 8'h92);
      check("p0_hex2", HEX2, 8'h82);
      check("p0_hex1", HEX1, 8'hF8);
      check("p0_hex0", HEX0, 8'h80);
      check("p0_led", {7'b0, PAGE_LED}, 8'h00);
      tick(4);

      // Held key: exactly one toggle, 7 edges after the raw change.
      KEY_PAGE = 1'b0;
      tick(6);
      check("press_not_yet", {7'b0, PAGE_LED}, 8'h00);
      tick(1);
      check("press_led", {7'b0, PAGE_LED}, 8'h01);
      check("p1_hex3", HEX3, 8'hF9);
      check("p1_hex2", HEX2, 8'hA4);
      check("p1_hex1", HEX1, 8'hB0);
      check("p1_hex0", HEX0, 8'h99);
      check("p1_hex4", HEX4, 8'hFF);
      check("p1_hex5", HEX5, 8'hB0);
      tick(13);
      check("hold_one_toggle", {7'b0, PAGE_LED}, 8'h01);
      KEY_PAGE = 1'b1;
      tick(10);
      check("release_no_toggle", {7'b0, PAGE_LED}, 8'h01);

      // Short glitches on both raw inputs are ignored.
      KEY_PAGE = 1'b0;
      tick(2);
      KEY_PAGE = 1'b1;
      tick(10);
      check("key_glitch", {7'b0, PAGE_LED}, 8'h01);
      FREEZE = 1'b1;
      tick(2);
      FREEZE = 1'b0;
      tick(10);
      check("frz_glitch_dp", HEX5, 8'hB0);

      // Back to page 0.
      KEY_PAGE = 1'b0;
      tick(10);
      KEY_PAGE = 1'b1;
      tick(10);
      check("back_p0_led", {7'b0, PAGE_LED}, 8'h00);
      check("back_p0_hex0", HEX0, 8'h80);

      // Live data latency: two edges.
      VDATA = 32'h12345679;
      tick(1);
      check("lat_1", HEX0, 8'h80);
      tick(1);
      check("lat_2", HEX0, 8'h90);
      VDATA = 32'h12345678;
      tick(3);

      // Freeze holds the snapshot and lights DP on HEX5.
      FREEZE = 1'b1;
      tick(10);
      check("frz_dp", HEX5, 8'h30);
      VDATA = 32'hDEADBEEF; SEL = 3'b110;
      tick(5);
      check("frz_hold_hex0", HEX0, 8'h80);
      check("frz_hold_hex5", HEX5, 8'h30);

      // Paging while frozen shows the held upper half and held SEL.
      KEY_PAGE = 1'b0;
      tick(10);
      KEY_PAGE = 1'b1;
      tick(10);
      check("frz_p1_led", {7'b0, PAGE_LED}, 8'h01);
      check("frz_p1_hex3", HEX3, 8'hF9);
      check("frz_p1_hex0", HEX0, 8'h99);
      check("frz_p1_hex5", HEX5, 8'h30);
      KEY_PAGE = 1'b0;
      tick(10);
      KEY_PAGE = 1'b1;
      tick(10);
      check("frz_p0_led", {7'b0, PAGE_LED}, 8'h00);

      // Unfreeze: live DEADBEEF appears on page 0.
      FREEZE = 1'b0;
      tick(10);
      check("live_hex5", HEX5, 8'h88);
      check("live_hex4", HEX4, 8'hA1);
      check("live_hex3", HEX3, 8'h83);
      check("live_hex2", HEX2, 8'h86);
      check("live_hex1", HEX1, 8'h86);
      check("live_hex0", HEX0, 8'h8E);

      // Freeze and press debounced on the same edge.
      VDATA = 32'h12345678;
      tick(3);
      FREEZE = 1'b1; KEY_PAGE = 1'b0;
      tick(5);
      VDATA = 32'hABCD0000; SEL = 3'b101;
      tick(1);
      VDATA = 32'h55550000; SEL = 3'b010;
      tick(1);
      check("same_led", {7'b0, PAGE_LED}, 8'h01);
      check("same_hex3", HEX3, 8'h88);
      check("same_hex2", HEX2, 8'h83);
      check("same_hex1", HEX1, 8'hC6);
      check("same_hex0", HEX0, 8'hA1);
      check("same_hex4", HEX4, 8'hFF);
      check("same_hex5", HEX5, 8'h12);

      // Reset while key is held: immediate blanking, no event until re-press.
      RST_N = 1'b0;
      #1;
      check_all_blank("midrst");
      @(negedge CLK);
      RST_N = 1'b1;
      tick(20);
      check("held_thru_reset", {7'b0, PAGE_LED}, 8'h00);
      KEY_PAGE = 1'b1;
      tick(10);
      check("release_after_reset", {7'b0, PAGE_LED}, 8'h00);
      KEY_PAGE = 1'b0;
      tick(10);
      check("repress_after_reset", {7'b0, PAGE_LED}, 8'h01);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
